// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter and store-strobe sequencer for a 4 x 8-bit
// level-store memory. Each access runs SETUP -> STROBE -> HOLD (write) or
// SETUP -> READ (read), then DONE. All outputs are registered.
// Optional per-port completion counters are enabled by defining MEM_ARB_STATS_EN.
module mem_access_arbiter #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [1:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_done,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [1:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_done,
  output logic [7:0] b_rdata,
  output logic [7:0] mem_data,
  output logic       mem_store,
  output logic [1:0] mem_addr,
  input  logic [7:0] mem_q,
  output logic       busy
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic       stats_clr,
  output logic [7:0] a_cnt,
  output logic [7:0] b_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRead,
    StDone
  } state_e;

  localparam logic [2:0] SetupLoad  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] StrobeLoad = 3'(STROBE_CYC - 1);

  state_e     state;
  logic [2:0] cnt;
  logic       we_lat;
  logic       sel_b;   // current access belongs to port B
  logic       prio_b;  // B wins the next tie (A was granted last)
  logic       grant_any;
  logic       grant_b;

  // Winner selection: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    grant_any = a_req | b_req;
    grant_b   = b_req & (~a_req | prio_b);
  end

  // Access sequencer; every output is a register so mem_store is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= 3'd0;
      we_lat    <= 1'b0;
      sel_b     <= 1'b0;
      prio_b    <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_rdata   <= 8'h00;
      b_rdata   <= 8'h00;
      mem_data  <= 8'h00;
      mem_addr  <= 2'd0;
      mem_store <= 1'b0;
      busy      <= 1'b0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        StIdle: begin
          if (grant_any) begin
            sel_b    <= grant_b;
            we_lat   <= grant_b ? b_we : a_we;
            mem_addr <= grant_b ? b_addr : a_addr;
            mem_data <= grant_b ? b_wdata : a_wdata;
            cnt      <= SetupLoad;
            busy     <= 1'b1;
            state    <= StSetup;
          end
        end
        StSetup: begin
          if (cnt == 3'd0) begin
            if (we_lat) begin
              mem_store <= 1'b1;
              cnt       <= StrobeLoad;
              state     <= StStrobe;
            end else begin
              state <= StRead;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        StStrobe: begin
          if (cnt == 3'd0) begin
            mem_store <= 1'b0;
            state     <= StHold;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        StHold: begin
          a_done <= ~sel_b;
          b_done <= sel_b;
          state  <= StDone;
        end
        StRead: begin
          if (sel_b) b_rdata <= mem_q;
          else       a_rdata <= mem_q;
          a_done <= ~sel_b;
          b_done <= sel_b;
          state  <= StDone;
        end
        StDone: begin
          prio_b <= ~sel_b;
          busy   <= 1'b0;
          state  <= StIdle;
        end
        default: begin
          mem_store <= 1'b0;
          busy      <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Completion counters: bump on the owning port's DONE cycle; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= 8'd0;
      b_cnt <= 8'd0;
    end else if (stats_clr) begin
      a_cnt <= 8'd0;
      b_cnt <= 8'd0;
    end else if (state == StDone) begin
      if (sel_b) b_cnt <= b_cnt + 8'd1;
      else       a_cnt <= a_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: a default-timing instance and a
// SETUP=3/STROBE=2 instance, each in front of a simple level-store memory.
module tb_mem_access_arbiter;

  localparam int DS = 1;  // fast instance setup cycles
  localparam int DT = 1;  // fast instance strobe cycles
  localparam int SS = 3;  // slow instance setup cycles
  localparam int ST = 2;  // slow instance strobe cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [1:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_done, b_done, mem_store, busy;
  logic [7:0] a_rdata, b_rdata, mem_data, mem_q;
  logic [1:0] mem_addr;

  logic       s_a_req = 0, s_a_we = 0;
  logic [1:0] s_a_addr = 0;
  logic [7:0] s_a_wdata = 0;
  logic       s_a_done, s_b_done, s_mem_store, s_busy;
  logic [7:0] s_a_rdata, s_b_rdata, s_mem_data, s_mem_q;
  logic [1:0] s_mem_addr;

`ifdef MEM_ARB_STATS_EN
  logic       stats_clr = 0;
  logic [7:0] a_cnt, b_cnt, s_a_cnt, s_b_cnt;
`endif

  // Level-store memories behind each instance.
  logic [7:0] phys   [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] phys_s [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  always @(posedge clk) if (mem_store) phys[mem_addr] <= mem_data;
  always @(posedge clk) if (s_mem_store) phys_s[s_mem_addr] <= s_mem_data;
  assign mem_q   = phys[mem_addr];
  assign s_mem_q = phys_s[s_mem_addr];

  mem_access_arbiter #(.SETUP_CYC(DS), .STROBE_CYC(DT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .mem_data(mem_data), .mem_store(mem_store), .mem_addr(mem_addr), .mem_q(mem_q),
    .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .a_cnt(a_cnt), .b_cnt(b_cnt)
`endif
  );

  mem_access_arbiter #(.SETUP_CYC(SS), .STROBE_CYC(ST)) u_slow (
    .clk(clk), .rst_n(rst_n),
    .a_req(s_a_req), .a_we(s_a_we), .a_addr(s_a_addr), .a_wdata(s_a_wdata),
    .a_done(s_a_done), .a_rdata(s_a_rdata),
    .b_req(1'b0), .b_we(1'b0), .b_addr(2'd0), .b_wdata(8'h00),
    .b_done(s_b_done), .b_rdata(s_b_rdata),
    .mem_data(s_mem_data), .mem_store(s_mem_store), .mem_addr(s_mem_addr), .mem_q(s_mem_q),
    .busy(s_busy)
`ifdef MEM_ARB_STATS_EN
    , .stats_clr(1'b0), .a_cnt(s_a_cnt), .b_cnt(s_b_cnt)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] exp_mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_a_rd = 8'h00;
  logic [7:0] exp_b_rd = 8'h00;
  bit         m_prio_b = 1'b0;

  // Runs one or two simultaneous requests on the fast instance and checks every cycle.
  task automatic run_access(input bit ao, input bit awe, input logic [1:0] aad,
                            input logic [7:0] awd, input bit bo, input bit bwe,
                            input logic [1:0] bad, input logic [7:0] bwd,
                            input bit perturb, input string tag);
    bit isb[2];
    bit we[2];
    logic [1:0] ad[2];
    logic [7:0] wd[2];
    int len[2];
    int start[2];
    int n, total;
    n = (ao && bo) ? 2 : 1;
    isb[0] = (ao && bo) ? m_prio_b : bo;
    isb[1] = !isb[0];
    for (int s = 0; s < 2; s++) begin
      we[s]  = isb[s] ? bwe : awe;
      ad[s]  = isb[s] ? bad : aad;
      wd[s]  = isb[s] ? bwd : awd;
      len[s] = we[s] ? (1 + DS + DT + 2) : (1 + DS + 2);
    end
    start[0] = 1;
    start[1] = 1 + len[0];
    total = (n == 2) ? len[0] + len[1] : len[0];
    a_req = ao; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = bo; b_we = bwe; b_addr = bad; b_wdata = bwd;
    for (int k = 1; k <= total + 1; k++) begin
      int cur, rel;
      bit e_busy, e_store, e_ad, e_bd, fin;
      cur = -1;
      rel = 0;
      if (k <= total) begin
        cur = (n == 2 && k >= start[1]) ? 1 : 0;
        rel = k - start[cur] + 1;
      end
      e_busy  = (cur >= 0) && rel >= 2;
      e_store = (cur >= 0) && we[cur] && rel >= DS + 2 && rel <= DS + DT + 1;
      fin     = (cur >= 0) && rel == len[cur];
      e_ad    = fin && !isb[cur];
      e_bd    = fin && isb[cur];
      @(negedge clk);
      n_cmp++;
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy k=%0d: got %b want %b", tag, k, busy, e_busy);
      end
      n_cmp++;
      if (mem_store !== e_store) begin
        n_fail++;
        $display("FAIL %s mem_store k=%0d: got %b want %b", tag, k, mem_store, e_store);
      end
      n_cmp++;
      if (a_done !== e_ad || b_done !== e_bd) begin
        n_fail++;
        $display("FAIL %s done k=%0d: got a=%b b=%b want a=%b b=%b",
                 tag, k, a_done, b_done, e_ad, e_bd);
      end
      if (e_busy) begin
        n_cmp++;
        if (mem_addr !== ad[cur]) begin
          n_fail++;
          $display("FAIL %s mem_addr k=%0d: got %0d want %0d", tag, k, mem_addr, ad[cur]);
        end
        if (we[cur]) begin
          n_cmp++;
          if (mem_data !== wd[cur]) begin
            n_fail++;
            $display("FAIL %s mem_data k=%0d: got %h want %h", tag, k, mem_data, wd[cur]);
          end
        end
      end
      if (fin) begin
        if (we[cur]) exp_mem[ad[cur]] = wd[cur];
        else if (isb[cur]) exp_b_rd = exp_mem[ad[cur]];
        else exp_a_rd = exp_mem[ad[cur]];
        m_prio_b = !isb[cur];
        n_cmp++;
        if (a_rdata !== exp_a_rd || b_rdata !== exp_b_rd) begin
          n_fail++;
          $display("FAIL %s rdata k=%0d: got a=%h b=%h want a=%h b=%h",
                   tag, k, a_rdata, b_rdata, exp_a_rd, exp_b_rd);
        end
      end
      if (perturb && mem_store) begin
        a_addr = 2'd1; a_wdata = 8'hFF;
        b_addr = 2'd1; b_wdata = 8'hFF;
      end
      @(posedge clk);
      #1;
      if (fin) begin
        if (isb[cur]) b_req = 1'b0;
        else a_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_done, b_done, a_rdata, b_rdata, mem_data, mem_store, mem_addr, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {a_done, b_done, a_rdata, b_rdata, mem_data, mem_store, mem_addr, busy});
    end
    n_cmp++;
    if ({s_a_done, s_a_rdata, s_mem_data, s_mem_store, s_mem_addr, s_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_slow_outputs: got %h want 0",
               {s_a_done, s_a_rdata, s_mem_data, s_mem_store, s_mem_addr, s_busy});
    end
`ifdef MEM_ARB_STATS_EN
    n_cmp++;
    if (a_cnt !== 8'd0 || b_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got a=%0d b=%0d want 0", a_cnt, b_cnt);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    run_access(1, 1, 2'd2, 8'hA5, 0, 0, 2'd0, 8'h00, 0, "wr_a5");
    run_access(1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00, 0, "rd_a5");
    n_cmp++;
    if (a_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_back_a5: got %h want a5", a_rdata);
    end
  endtask

  task automatic test_arbitration();
    run_access(1, 1, 2'd0, 8'h11, 1, 1, 2'd1, 8'h22, 0, "arb_w1");
    run_access(1, 1, 2'd0, 8'h11, 1, 1, 2'd1, 8'h22, 0, "arb_w2");
    run_access(1, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00, 0, "arb_rd");
    n_cmp++;
    if (a_rdata !== 8'h11 || b_rdata !== 8'h22) begin
      n_fail++;
      $display("FAIL arb_readback: got a=%h b=%h want a=11 b=22", a_rdata, b_rdata);
    end
  endtask

  task automatic test_mid_change();
    run_access(0, 0, 2'd0, 8'h00, 1, 1, 2'd3, 8'h3C, 1, "mid_wr");
    run_access(0, 0, 2'd0, 8'h00, 1, 0, 2'd3, 8'h00, 0, "mid_rd3");
    n_cmp++;
    if (b_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL mid_addr3: got %h want 3c", b_rdata);
    end
    run_access(0, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00, 0, "mid_rd1");
    n_cmp++;
    if (b_rdata !== 8'h22) begin
      n_fail++;
      $display("FAIL mid_addr1: got %h want 22", b_rdata);
    end
  endtask

  task automatic test_long_setup();
    logic [1:0] ad0;
    logic [7:0] wd0;
    ad0 = 2'($urandom_range(0, 3));
    wd0 = 8'($urandom_range(1, 255));
    for (int op = 0; op < 2; op++) begin
      bit we;
      int len, st_hi;
      we = (op == 0);
      len = we ? (1 + SS + ST + 2) : (1 + SS + 2);
      st_hi = 0;
      s_a_req = 1'b1; s_a_we = we; s_a_addr = ad0; s_a_wdata = we ? wd0 : 8'h00;
      for (int k = 1; k <= len + 1; k++) begin
        bit e_store, e_done, e_busy;
        e_store = we && k >= SS + 2 && k <= SS + ST + 1;
        e_done  = (k == len);
        e_busy  = k >= 2 && k <= len;
        @(negedge clk);
        if (s_mem_store) st_hi++;
        n_cmp++;
        if (s_mem_store !== e_store || s_a_done !== e_done || s_busy !== e_busy) begin
          n_fail++;
          $display("FAIL slow_ctrl op=%0d k=%0d: got st=%b dn=%b bz=%b want st=%b dn=%b bz=%b",
                   op, k, s_mem_store, s_a_done, s_busy, e_store, e_done, e_busy);
        end
        if (k >= 2 && k < len) begin
          n_cmp++;
          if (s_mem_addr !== ad0 || (we && s_mem_data !== wd0)) begin
            n_fail++;
            $display("FAIL slow_stable op=%0d k=%0d: got %0d/%h want %0d/%h",
                     op, k, s_mem_addr, s_mem_data, ad0, wd0);
          end
        end
        if (k == len && !we) begin
          n_cmp++;
          if (s_a_rdata !== wd0) begin
            n_fail++;
            $display("FAIL slow_rdata: got %h want %h", s_a_rdata, wd0);
          end
        end
        @(posedge clk);
        #1;
        if (k == len) s_a_req = 1'b0;
      end
      n_cmp++;
      if (st_hi !== (we ? ST : 0)) begin
        n_fail++;
        $display("FAIL slow_store_width op=%0d: got %0d want %0d", op, st_hi, we ? ST : 0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit ao, bo;
      ao = 1'($urandom_range(0, 1));
      bo = 1'($urandom_range(0, 1));
      if (!ao && !bo) ao = 1'b1;
      run_access(ao, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 bo, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 0, "random");
    end
  endtask

  task automatic test_reset_abort();
    int k;
    k = 0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd0; a_wdata = 8'h77;
    while (k < 6 && mem_store !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != DS + 2) begin
      n_fail++;
      $display("FAIL abort_strobe_cycle: got %0d want %0d", k, DS + 2);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_store !== 1'b0 || busy !== 1'b0 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: got st=%b bz=%b dn=%b want 0", mem_store, busy, a_done);
    end
    a_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (a_done !== 1'b0 || mem_store !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_held: got dn=%b st=%b bz=%b want 0", a_done, mem_store, busy);
      end
    end
    rst_n = 1'b1;
    m_prio_b = 1'b0;
    exp_a_rd = 8'h00;
    exp_b_rd = 8'h00;
    @(posedge clk);
    #1;
    n_cmp++;
    if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_rdata: got a=%h b=%h want 0", a_rdata, b_rdata);
    end
    run_access(1, 1, 2'd0, 8'h5E, 0, 0, 2'd0, 8'h00, 0, "post_abort_wr");
    run_access(1, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, "post_abort_rd");
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    int seen;
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    n_cmp++;
    if (a_cnt !== 8'd0 || b_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL stats_clr: got a=%0d b=%0d want 0", a_cnt, b_cnt);
    end
    for (int i = 0; i < 300; i++)
      run_access(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 0, 0, 2'd0, 8'h00, 0, "stats_a");
    for (int i = 0; i < 2; i++)
      run_access(0, 0, 2'd0, 8'h00, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 8'($urandom), 0, "stats_b");
    n_cmp++;
    if (a_cnt !== 8'(300 % 256) || b_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL stats_counts: got a=%0d b=%0d want a=%0d b=2", a_cnt, b_cnt, 300 % 256);
    end
    seen = 0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd2;
    for (int k = 1; k <= 8 && seen == 0; k++) begin
      @(negedge clk);
      if (a_done === 1'b1) begin
        seen = k;
        stats_clr = 1'b1;
      end
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      if (seen != 0) a_req = 1'b0;
    end
    exp_a_rd = exp_mem[2];
    m_prio_b = 1'b1;
    n_cmp++;
    if (seen != 1 + DS + 2) begin
      n_fail++;
      $display("FAIL stats_clr_done_cycle: got %0d want %0d", seen, 1 + DS + 2);
    end
    n_cmp++;
    if (a_cnt !== 8'd0 || b_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL stats_clr_wins: got a=%0d b=%0d want 0", a_cnt, b_cnt);
    end
    n_cmp++;
    if (a_rdata !== exp_a_rd) begin
      n_fail++;
      $display("FAIL stats_clr_rdata: got %h want %h", a_rdata, exp_a_rd);
    end
    run_access(1, 1, 2'd1, 8'h9D, 0, 0, 2'd0, 8'h00, 0, "stats_after_clr");
    n_cmp++;
    if (a_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL stats_restart: got %0d want 1", a_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_mid_change();
    test_long_setup();
    test_random();
    test_reset_abort();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
